// File: rtl/seq_pkg.sv
// Shared types and constants for the serial frame generator.
package seq_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_PAT_LEN = 4;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
  // Upper bound on frame width that the replication helper can build.
  localparam int MAX_WIDTH = 256;

  // Tile a pat_len-bit pattern across the low 'width' bits, LSB-aligned.
  // The pattern's MSB therefore lands on bit width-1, the first bit sent.
  function automatic logic [MAX_WIDTH-1:0] replicate_pattern(
    input logic [MAX_WIDTH-1:0] pat,
    input int pat_len,
    input int width
  );
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++)
      if (i < width) r[i] = pat[i % pat_len];
    return r;
  endfunction

endpackage

// File: rtl/sequence_generator_serializer_piso.sv
// Parallel-in / serial-out shift register; msb is the bit currently on the line.
module piso_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  // Zero fill means a fully shifted-out frame leaves the line at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sr_q <= '0;
    else if (load)  sr_q <= din;
    else if (shift) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/sequence_generator_serializer.sv
// Frame serializer: valid/ready word intake, MSB-first bit stream with sof/eof strobes.
module sequence_generator_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PAT_LEN = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             mode,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] PAT_WORD =
    WIDTH'(replicate_pattern(MAX_WIDTH'(PATTERN), PAT_LEN, WIDTH));

  if (WIDTH < 2 || WIDTH > MAX_WIDTH || (WIDTH % PAT_LEN) != 0) begin : g_bad_params
    $fatal(1, "sequence_generator_serializer: WIDTH must be 2..MAX_WIDTH and a multiple of PAT_LEN");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          sof_q, eof_q;
  logic [15:0]   frames_q;
  logic          accept;

  // Ready reopens during the last bit so frames can abut without a gap.
  always_comb begin
    load_ready = (state_q == IDLE) || eof_q;
    accept     = load_valid && load_ready;
    state_d    = state_q;
    if (state_q == IDLE) begin
      if (accept) state_d = SHIFT;
    end else begin
      if (eof_q && !accept) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        sof_q <= 1'b1;
        eof_q <= 1'b0;
      end else if (state_q == SHIFT) begin
        cnt_q <= eof_q ? '0 : cnt_q + 1'b1;
        sof_q <= 1'b0;
        eof_q <= !eof_q && (cnt_q == LAST - 1'b1);
      end else begin
        sof_q <= 1'b0;
        eof_q <= 1'b0;
      end
      if (eof_q) frames_q <= frames_q + 16'd1;
    end
  end

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .din   (mode ? PAT_WORD : load_data),
    .shift (state_q == SHIFT),
    .msb   (sout)
  );

  assign sout_valid  = (state_q == SHIFT);
  assign busy        = (state_q == SHIFT);
  assign sof         = sof_q;
  assign eof         = eof_q;
  assign frames_sent = frames_q;

endmodule
